cavlc_level_encoder: RTL

- Reads the level list built by the CAVLC level collector: non-zero coefficients that follow the trailing ones, in coding order.
- Converts each level into an H.264 level_prefix/level_suffix codeword (clause 9.2.2) and adapts suffixLength after each level.
- Emits one codeword per level over a valid/ready handshake to the CAVLC bit packer.
- Sits between the level collector and the bitstream packer in the h264_encoder CAVLC path.

---
 rtl/cavlc_level_encoder_if.sv | 9 +
 rtl/cavlc_level_encoder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/cavlc_level_encoder_if.sv
// cavlc_level_encoder_if: codeword valid/ready channel from the level encoder to the CAVLC bit packer.
interface cavlc_level_encoder_if #(parameter int CODE_W = 28);
    logic [CODE_W-1:0] code_o;
    logic [4:0]        code_len_o;
    logic              code_valid_o;
    logic              code_ready_i;
    modport master (output code_o, code_len_o, code_valid_o, input code_ready_i);
    modport slave  (input code_o, code_len_o, code_valid_o, output code_ready_i);
endinterface

// File: rtl/cavlc_level_encoder.sv
// cavlc_level_encoder: turns the CAVLC level list into level_prefix/level_suffix codewords.
// Define CAVLC_LEVEL_STATS_EN to add total_bits_o, the per-block sum of emitted codeword lengths.
module cavlc_level_encoder #(
    parameter int LIST_DEPTH = 16,
    parameter int LEVEL_W    = 8,
    parameter int CODE_W     = 28
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_i,
    input  logic [LIST_DEPTH-1:0][LEVEL_W-1:0] level_code_list,
    input  logic [4:0]                         level_code_cnt,
    input  logic [4:0]                         total_coeff_i,
    input  logic [1:0]                         trailing_ones_i,
    cavlc_level_encoder_if.master              cw,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_o
`ifdef CAVLC_LEVEL_STATS_EN
    ,
    output logic [8:0]                         total_bits_o
`endif
);
    localparam int IW   = $clog2(LIST_DEPTH);
    localparam int MW   = LEVEL_W + 1;
    localparam int LC_W = LEVEL_W + 2;

    typedef enum logic [2:0] {IDLE, INIT, CALC, OUT, DONE} state_t;
    state_t state, state_n;

    logic [4:0]              idx, cnt;
    logic [2:0]              sl, sl1, sl_up;
    logic                    err;
    logic [CODE_W-1:0]       code_q, code_n;
    logic [4:0]              len_q, len_n;
    logic signed [LEVEL_W-1:0] level;
    logic signed [MW-1:0]    lev_x;
    logic [MW-1:0]           mag;
    logic [LC_W-1:0]         lc_adj, lcu, thr, sfx_mask;
    logic                    under;

    assign level = level_code_list[idx[IW-1:0]];
    assign lev_x = {level[LEVEL_W-1], level};
    assign mag   = lev_x[MW-1] ? -lev_x : lev_x;
    // Two's-complement levelCode; the first level loses 2 when fewer than 3 trailing ones precede it.
    assign lc_adj = {mag, 1'b0} - ((level > 0) ? LC_W'(2) : LC_W'(1))
                  - ((idx == 5'd0 && trailing_ones_i != 2'd3) ? LC_W'(2) : LC_W'(0));
    assign under    = lc_adj[LC_W-1];
    assign lcu      = under ? '0 : lc_adj;
    assign thr      = (sl == 3'd0) ? LC_W'(30) : LC_W'(15) << sl;
    assign sfx_mask = (LC_W'(1) << sl) - 1'b1;
    assign sl1      = (sl == 3'd0) ? 3'd1 : sl;
    assign sl_up    = (mag > (MW'(3) << (sl1 - 3'd1)) && sl1 < 3'd6) ? sl1 + 3'd1 : sl1;

    always_comb begin
        code_n = '0;
        len_n  = '0;
        if (lcu >= thr) begin
            code_n = CODE_W'({1'b1, 12'(lcu - thr)});
            len_n  = 5'd28;
        end else if (sl == 3'd0) begin
            code_n = (lcu < LC_W'(14)) ? CODE_W'(1) : CODE_W'({1'b1, 4'(lcu - LC_W'(14))});
            len_n  = (lcu < LC_W'(14)) ? 5'(lcu + 1'b1) : 5'd19;
        end else begin
            code_n = CODE_W'((LC_W'(1) << sl) | (lcu & sfx_mask));
            len_n  = 5'((lcu >> sl) + LC_W'(sl) + 1'b1);
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start_i ? INIT : IDLE;
            INIT:    state_n = (level_code_cnt == 5'd0) ? DONE : CALC;
            CALC:    state_n = OUT;
            OUT:     state_n = !cw.code_ready_i ? OUT : (idx == cnt - 5'd1) ? DONE : CALC;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            cnt    <= '0;
            sl     <= '0;
            err    <= 1'b0;
            code_q <= '0;
            len_q  <= '0;
        end else begin
            case (state)
                INIT: begin
                    idx <= '0;
                    cnt <= (level_code_cnt > 5'd16) ? 5'd16 : level_code_cnt;
                    sl  <= (total_coeff_i > 5'd10 && trailing_ones_i != 2'd3) ? 3'd1 : 3'd0;
                    err <= 1'b0;
                end
                CALC: begin
                    code_q <= code_n;
                    len_q  <= len_n;
                    if (under) err <= 1'b1;
                end
                OUT: if (cw.code_ready_i) begin
                    sl  <= sl_up;
                    idx <= idx + 5'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef CAVLC_LEVEL_STATS_EN
    logic [8:0] total_bits;
    always_ff @(posedge clk or posedge rst)
        if (rst)                                      total_bits <= '0;
        else if (state == INIT)                       total_bits <= '0;
        else if (state == OUT && cw.code_ready_i)     total_bits <= total_bits + 9'(len_q);
    assign total_bits_o = total_bits;
`endif

    assign cw.code_o       = code_q;
    assign cw.code_len_o   = len_q;
    assign cw.code_valid_o = (state == OUT);
    assign busy_o          = (state == INIT) || (state == CALC) || (state == OUT);
    assign done_o          = (state == DONE);
    assign err_o           = err;
endmodule
